// File: rtl/comp_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package comp_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;

    function automatic int slices(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/two_bit_gt.sv
// Two-bit unsigned greater-than stage: agtb = (a > b).
module two_bit_gt (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       agtb
);

    assign agtb = (a[1] & ~b[1]) |
                  (a[0] & ~b[1] & ~b[0]) |
                  (a[1] & a[0] & ~b[0]);

endmodule

// File: rtl/serial_mag_comparator.sv
// MSB-first serial magnitude comparator: one 2-bit slice per clock, stops at
// the first differing slice and reports greater / equal / less.
module serial_mag_comparator
    import comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             agtb,
    output logic             aeqb,
    output logic             altb
);

    localparam int SLICES = slices(WIDTH);
    localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

    generate
        if ((WIDTH < 2) || (WIDTH % 2 != 0)) begin : g_bad_width
            $error("serial_mag_comparator: WIDTH must be even and >= 2");
        end
    endgenerate

    cmp_state_t       state, state_next;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             gt, lt;
    logic             accept;

    // Same stage twice: swapping the operands gives the less-than decision.
    two_bit_gt u_gt (
        .a    (sa[WIDTH-1 -: 2]),
        .b    (sb[WIDTH-1 -: 2]),
        .agtb (gt)
    );

    two_bit_gt u_lt (
        .a    (sb[WIDTH-1 -: 2]),
        .b    (sa[WIDTH-1 -: 2]),
        .agtb (lt)
    );

    assign accept = start && (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = start ? RUN : IDLE;
            RUN:        if (gt || lt || (cnt == '0)) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sa   <= '0;
            sb   <= '0;
            cnt  <= '0;
            agtb <= 1'b0;
            aeqb <= 1'b0;
            altb <= 1'b0;
        end else if (accept) begin
            sa   <= a;
            sb   <= b;
            cnt  <= CW'(SLICES - 1);
            agtb <= 1'b0;
            aeqb <= 1'b0;
            altb <= 1'b0;
        end else if (state == RUN) begin
            if (gt) begin
                agtb <= 1'b1;
            end else if (lt) begin
                altb <= 1'b1;
            end else if (cnt == '0) begin
                aeqb <= 1'b1;
            end else begin
                sa  <= sa << 2;
                sb  <= sb << 2;
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule
